// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - DATA_W (fixed 32 for RV32I)
//   - f3_legal(): tells whether a funct3 is a real load or store encoding
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        STORE_RD = 3'd2,
        STORE_WR = 3'd3,
        ERR      = 3'd4
    } lsu_state_t;

    // Stores only have the signed encodings; the unsigned variants exist
    // for loads alone.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword lane out of a memory
// word (little-endian) and sign- or zero-extends it to 32 bits.
// Ports:
//   word   in  DATA_W  memory word
//   lane   in  2       byte offset within the word (addr[1:0])
//   funct3 in  3       load type
//   ext    out DATA_W  extended load value
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]               byte_u;
    logic [15:0]              half_u;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] byte_sx;
    logic signed [DATA_W-1:0] half_sx;

    always_comb begin
        byte_u  = word[{lane, 3'b000} +: 8];
        half_u  = word[{lane[1], 4'b0000} +: 16];
        byte_s  = $signed(byte_u);
        half_s  = $signed(half_u);
        // Signed-to-wider-signed assignment replicates the sign bit.
        byte_sx = byte_s;
        half_sx = half_s;

        ext = word;
        case (funct3)
            F3_B:    ext = byte_sx;
            F3_H:    ext = half_sx;
            F3_BU:   ext = {{(DATA_W-8){1'b0}}, byte_u};
            F3_HU:   ext = {{(DATA_W-16){1'b0}}, half_u};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte-addressed RV32I loads/stores into accesses
// on a word-organised Data_Memory. Sub-word stores use read-modify-write.
// Misaligned, out-of-range and illegal-funct3 requests complete with rsp_err.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (accept on valid && ready)
//   req_we, req_funct3      store flag, RV32I funct3
//   req_addr, req_wdata     byte address, store data
//   rsp_valid               one-cycle completion pulse
//   rsp_err, rsp_rdata      error flag, extended load data (held)
//   mem_w_en, mem_addr      Data_Memory write enable, word index
//   mem_din, mem_dout       Data_Memory write data, read data (comb.)
module load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    import lsu_pkg::*;

    lsu_state_t        state_q, state_d;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [15:0]       wdata_q;
    logic [DATA_W-1:0] merge_q;

    logic              req_illegal, req_misaligned, req_range, req_bad;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merged;

    // Request classification (only consulted on the accepting edge)
    always_comb begin
        req_illegal    = !f3_legal(req_we, req_funct3);
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_range      = (req_addr >> (ADDR_W + 2)) != 32'd0;
        req_bad        = req_illegal || req_misaligned || req_range;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)                  state_d = ERR;
                    else if (!req_we)             state_d = LOAD;
                    else if (req_funct3 == F3_W)  state_d = STORE_WR;
                    else                          state_d = STORE_RD;
                end
            end
            LOAD:     state_d = IDLE;
            STORE_RD: state_d = STORE_WR;
            STORE_WR: state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Decoded from the state register so reset removes the write at once.
    assign req_ready = (state_q == IDLE);
    assign mem_w_en  = (state_q == STORE_WR);
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_din   = merge_q;

    lsu_load_align u_align (
        .word   (mem_dout),
        .lane   (addr_q[1:0]),
        .funct3 (funct3_q),
        .ext    (load_val)
    );

    // Sub-word store lane merge onto the word read back in STORE_RD
    always_comb begin
        merged = mem_dout;
        if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                        merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q;
    end

    // Captured request, merge register and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr[ADDR_W+1:0];
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata[15:0];
                        // SW writes rs2 straight through; RMW overwrites this.
                        merge_q  <= req_wdata;
                    end
                end
                LOAD: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_val;
                end
                STORE_RD: merge_q <= merged;
                STORE_WR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
